// File: rtl/fourbits_restoring_divider.sv
// rtl/fourbits_restoring_divider.sv - sequential unsigned restoring divider, one quotient bit per clock
// Valid/ready request in, valid/ready result out; b==0 short-circuits to a flagged result.
module fourbits_restoring_divider #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             dbz_q, dbz_d;

   // A restored remainder is always below b, so R only needs WIDTH bits between
   // steps; the shifted partial remainder and the trial difference carry WIDTH+1.
   logic [WIDTH:0]   r_shift;
   logic [WIDTH:0]   diff;
   logic             borrow;
   logic [WIDTH-1:0] r_next;
   logic [WIDTH-1:0] q_next;

   assign r_shift = {r_q, q_q[WIDTH-1]};
   assign diff    = r_shift + {1'b1, ~b_q} + {{WIDTH{1'b0}}, 1'b1};
   assign borrow  = diff[WIDTH];
   assign r_next  = borrow ? r_shift[WIDTH-1:0] : diff[WIDTH-1:0];
   assign q_next  = {q_q[WIDTH-2:0], ~borrow};

   always_comb begin
      state_d     = state_q;
      r_d         = r_q;
      q_d         = q_q;
      b_d         = b_q;
      cnt_d       = cnt_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               b_d   = b;
               q_d   = a;
               r_d   = '0;
               cnt_d = '0;
               if (b != '0) begin
                  state_d = CALC;
               end else begin
                  state_d     = DONE;
                  quotient_d  = '1;
                  remainder_d = a;
                  dbz_d       = 1'b1;
               end
            end
         end
         CALC: begin
            r_d   = r_next;
            q_d   = q_next;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d     = DONE;
               quotient_d  = q_next;
               remainder_d = r_next;
               dbz_d       = 1'b0;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         r_q         <= '0;
         q_q         <= '0;
         b_q         <= '0;
         cnt_q       <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         r_q         <= r_d;
         q_q         <= q_d;
         b_q         <= b_d;
         cnt_q       <= cnt_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
      end
   end

   assign in_ready    = (state_q == IDLE);
   assign out_valid   = (state_q == DONE);
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_fourbits_restoring_divider.sv
// tb/tb_fourbits_restoring_divider.sv - randomized and swept check of the restoring divider
// Reference results come from plain / and % with the b==0 rule applied on top.
module tb_fourbits_restoring_divider;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fourbits_restoring_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a           (a),
      .b           (b),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic ref_div(input int ai, input int bi, output int q, output int r, output int z);
      if (bi == 0) begin
         q = (1 << W) - 1;
         r = ai;
         z = 1;
      end else begin
         q = ai / bi;
         r = ai % bi;
         z = 0;
      end
   endtask

   // One request: accept, count edges to out_valid, hold out_ready low for
   // `stall` cycles in DONE, then release and confirm the return to IDLE.
   task automatic do_op(input int ai, input int bi, input int stall);
      int eq, er, ez, lat, exp_lat;
      ref_div(ai, bi, eq, er, ez);
      exp_lat = (bi == 0) ? 1 : W + 1;
      @(negedge clk);
      chk("in_ready_idle", 32'(in_ready), 32'd1);
      a         = W'(ai);
      b         = W'(bi);
      in_valid  = 1'b1;
      out_ready = (stall == 0);
      @(posedge clk);
      #1;
      lat = 1;
      while (!out_valid && lat < 20) begin
         chk("in_ready_busy", 32'(in_ready), 32'd0);
         in_valid = 1'($urandom);
         a        = W'($urandom);
         b        = W'($urandom);
         @(posedge clk);
         #1;
         lat++;
      end
      in_valid = 1'b0;
      chk("latency", 32'(lat), 32'(exp_lat));
      chk("quotient", 32'(quotient), 32'(eq));
      chk("remainder", 32'(remainder), 32'(er));
      chk("div_by_zero", 32'(div_by_zero), 32'(ez));
      chk("in_ready_done", 32'(in_ready), 32'd0);
      for (int s = 0; s < stall; s++) begin
         @(posedge clk);
         #1;
         chk("stall_valid", 32'(out_valid), 32'd1);
         chk("stall_in_ready", 32'(in_ready), 32'd0);
         chk("stall_q", 32'(quotient), 32'(eq));
         chk("stall_r", 32'(remainder), 32'(er));
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("valid_drop", 32'(out_valid), 32'd0);
      chk("in_ready_back", 32'(in_ready), 32'd1);
   endtask

   initial begin
      int seen;
      #2;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_q", 32'(quotient), 32'd0);
      chk("rst_r", 32'(remainder), 32'd0);
      chk("rst_dbz", 32'(div_by_zero), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      do_op(13, 3, 0);
      do_op(15, 1, 0);
      do_op(2, 7, 0);
      do_op(5, 0, 0);
      do_op(9, 2, 3);
      do_op(0, 5, 0);
      do_op(6, 6, 1);

      // Reset two edges into CALC: result discarded, outputs back to reset values.
      @(negedge clk);
      a        = 4'd14;
      b        = 4'd3;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_q", 32'(quotient), 32'd0);
      chk("mid_rst_r", 32'(remainder), 32'd0);
      chk("mid_rst_dbz", 32'(div_by_zero), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (out_valid) seen++;
      end
      chk("mid_rst_no_valid", 32'(seen), 32'd0);

      for (int ai = 0; ai < 16; ai++)
         for (int bi = 0; bi < 16; bi++)
            do_op(ai, bi, int'($urandom_range(0, 2)));

      repeat (100) do_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                         int'($urandom_range(0, 3)));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
